// File: rtl/nipcb_rec_packer_if.sv
// nipcb_rec_packer_if: recording-FIFO read port and packet stream
// bundled between the packer and its surroundings.
interface nipcb_rec_packer_if;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/nipcb_rec_packer.sv
// nipcb_rec_packer: drains a recording FIFO into SYNC-headed stream
// packets of up to N words, flushing partial packets on idle timeout.
module nipcb_rec_packer #(
  parameter int         PKT_MAX = 16,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        clear,
  input  logic [7:0]  cfg_pkt_words,
  input  logic [31:0] cfg_timeout,
  output logic [7:0]  seq,
  output logic        busy,
  nipcb_rec_packer_if.master bus
);
  localparam int AW = $clog2(PKT_MAX);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PMAX = CW'(PKT_MAX);
  localparam logic [AW-1:0] A0 = '0;

  typedef enum logic [1:0] {IDLE, FILL, HDR, PAYLOAD} state_t;
  state_t state_q, state_d;

  logic [31:0]   mem [PKT_MAX];
  logic [CW-1:0] n_q, n_cfg;
  logic [CW-1:0] fill_q, idx_q, idx_nx;
  logic [31:0]   timer_q;
  logic [7:0]    seq_q;
  logic          rd_q, rd_en;
  logic          hs, to_hdr, to_idle;
  logic [31:0]   hdr;
  logic [31:0]   tdata_q;
  logic          tvalid_q, tlast_q;

  always_comb begin
    n_cfg = CW'(cfg_pkt_words);
    if (cfg_pkt_words == 8'd0)
      n_cfg = CW'(1);
    else if ({1'b0, cfg_pkt_words} > 9'(PKT_MAX))
      n_cfg = PMAX;
  end

  assign hs     = tvalid_q & bus.m_tready;
  assign idx_nx = idx_q + CW'(1);
  assign hdr    = {SYNC, seq_q, 8'h00, 8'(fill_q)};

  assign to_hdr = (state_q == FILL) && !rd_q
                && (fill_q != '0)
                && ((fill_q == n_q)
                 || ((cfg_timeout != '0)
                  && (timer_q >= cfg_timeout)));

  assign to_idle = (state_q == FILL) && !enable
                 && (fill_q == '0) && !rd_q;

  // Reads are withheld on the leaving cycle so no word lands
  // after the header has already latched the fill count.
  assign rd_en = rstn && !clear
               && (state_q == FILL)
               && !bus.fifo_empty
               && ((fill_q + CW'(rd_q)) < n_q)
               && !to_hdr && !to_idle;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = FILL;
      FILL: begin
        if (to_hdr)       state_d = HDR;
        else if (to_idle) state_d = IDLE;
      end
      HDR:     if (hs) state_d = PAYLOAD;
      PAYLOAD: begin
        if (hs && tlast_q)
          state_d = enable ? FILL : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rstn && !clear && rd_q)
      mem[fill_q[AW-1:0]] <= bus.fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q     <= 1'b0;
      fill_q   <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      seq_q    <= '0;
      n_q      <= CW'(1);
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (clear) begin
      rd_q     <= 1'b0;
      fill_q   <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      seq_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      rd_q <= rd_en;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            fill_q  <= '0;
            timer_q <= '0;
            n_q     <= n_cfg;
          end
        end
        FILL: begin
          if (rd_q) begin
            fill_q  <= fill_q + CW'(1);
            timer_q <= '0;
          end else if (fill_q != '0 && timer_q != '1) begin
            timer_q <= timer_q + 32'd1;
          end
          if (to_hdr) begin
            tdata_q  <= hdr;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
          end
        end
        HDR: begin
          if (hs) begin
            idx_q   <= '0;
            tdata_q <= mem[A0];
            tlast_q <= (fill_q == CW'(1));
          end
        end
        PAYLOAD: begin
          if (hs && tlast_q) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            seq_q    <= seq_q + 8'd1;
            fill_q   <= '0;
            timer_q  <= '0;
            idx_q    <= '0;
            n_q      <= n_cfg;
          end else if (hs) begin
            idx_q   <= idx_nx;
            tdata_q <= mem[idx_nx[AW-1:0]];
            tlast_q <= ((idx_nx + CW'(1)) == fill_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_tdata    = tdata_q;
  assign bus.m_tvalid   = tvalid_q;
  assign bus.m_tlast    = tlast_q;
  assign seq            = seq_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: doc/nipcb_rec_packer.md
NIPCB_REC_PACKER -- requirements
Module: nipcb_rec_packer

Interface
REQ-001 Parameter: PKT_MAX, 16, payload buffer depth in 32-bit words (power of 2, 2..256).
REQ-002 Parameter: SYNC, 8'hA5, header sync byte.
REQ-003 Port: clk  in  1  clock, all logic on rising edge.
REQ-004 Port: rstn  in  1  reset, synchronous, active-low.
REQ-005 Port: enable  in  1  level; high allows new packets to start.
REQ-006 Port: clear  in  1  one-cycle pulse; abort, flush buffer, zero sequence.
REQ-007 Port: cfg_pkt_words  in  8  target payload words per packet.
REQ-008 Port: cfg_timeout  in  32  idle cycles before a partial packet is flushed; 0 disables flush.
REQ-009 Port: fifo_rd_en  out  1  read strobe to the recording FIFO.
REQ-010 Port: fifo_dout  in  32  FIFO read data, valid exactly 1 cycle after fifo_rd_en (standard, non-FWFT).
REQ-011 Port: fifo_empty  in  1  FIFO empty flag.
REQ-012 Port: m_tdata  out  32  stream data.
REQ-013 Port: m_tvalid  out  1  stream valid.
REQ-014 Port: m_tready  in  1  stream ready.
REQ-015 Port: m_tlast  out  1  last word of packet.
REQ-016 Port: seq  out  8  sequence number of the next packet to be emitted.
REQ-017 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 States SHALL be IDLE, FILL, HDR, PAYLOAD.
REQ-019 Effective target N SHALL be 1 when cfg_pkt_words==0, PKT_MAX when cfg_pkt_words>PKT_MAX, else cfg_pkt_words; N SHALL be sampled on IDLE->FILL and PAYLOAD->FILL and held for the packet.
REQ-020 IDLE->FILL SHALL occur when enable==1; fill count and timer SHALL be zeroed.
REQ-021 In FILL, fifo_rd_en SHALL be 1 iff ~fifo_empty and (fill count + reads in flight) < N; fifo_rd_en SHALL never be asserted outside FILL.
REQ-022 Every fifo_rd_en SHALL be followed by capture of fifo_dout into buffer[fill count] the next cycle, regardless of state change, and fill count SHALL increment.
REQ-023 Timer SHALL count cycles in FILL while fill count>0 and no word is captured; it SHALL zero on each capture.
REQ-024 FILL->HDR SHALL occur when fill count==N with no read in flight, or when cfg_timeout!=0, fill count>0, no read in flight and timer>=cfg_timeout.
REQ-025 FILL->IDLE SHALL occur when enable==0, fill count==0 and no read in flight; otherwise enable==0 SHALL let the current packet complete.
REQ-026 HDR SHALL present m_tdata={SYNC, seq, 8'h00, fill count (8 bits)}, m_tvalid=1, m_tlast=0; on m_tvalid&m_tready -> PAYLOAD, read index=0.
REQ-027 PAYLOAD SHALL present buffer[index], m_tvalid=1, m_tlast=1 iff index==fill count-1; index advances on each handshake.
REQ-028 On the tlast handshake seq SHALL increment modulo 256 (255->0) and state SHALL go to FILL if enable, else IDLE.
REQ-029 m_tdata/m_tlast SHALL remain stable while m_tvalid&~m_tready; m_tvalid SHALL not drop before handshake except on clear or reset.
REQ-030 m_tvalid SHALL be 0 in IDLE and FILL; m_tdata don't-care when m_tvalid==0 but SHALL be registered.
REQ-031 clear SHALL, on the next edge, force IDLE, zero seq, fill count, index, timer, m_tvalid, m_tlast; an in-flight FIFO read word SHALL be discarded; clear has priority over all other events.
REQ-032 Packets SHALL never exceed N payload words nor be emitted with zero payload words.

Reset
REQ-033 While rstn==0 at a clk edge: state=IDLE, fifo_rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, seq=0, busy=0, fill count/index/timer=0.
REQ-034 Reset mid-packet SHALL drop the packet; first packet after reset SHALL carry seq=0.

Verification
REQ-035 N=4, enable=1, FIFO holds 32'h11..,32'h22..,32'h33..,32'h44.., tready=1 -> header 32'hA5000004 then four words in order, tlast on fourth, seq=1 after.
REQ-036 N=4, only 2 words ever available, cfg_timeout=10 -> header 32'hA5000002 after 10 idle cycles, 2 payload words, tlast on second; cfg_timeout=0 -> no output.
REQ-037 tready toggled 1-0-0-1 pseudo-randomly during 3 back-to-back packets -> data/tlast stable under stall, no loss/duplication, seq 0,1,2 in headers.
REQ-038 cfg_pkt_words=0 -> one-word packets; cfg_pkt_words=200 with PKT_MAX=16 -> 16-word packets.
REQ-039 clear asserted in PAYLOAD after 2 of 4 words -> m_tvalid=0 next cycle, next header has seq=0, no stale words emitted.
REQ-040 257 packets streamed -> seq wraps 255->0 in header of packet 257.
